// File: rtl/maria_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maria_arb_pkg
// Description : Shared types and constants for the Maria bus arbiter:
//               arbiter state encoding, parameter bounds and the default
//               per-grant hold budget.
// Revision    : 1.0 - initial release
// ============================================================================
package maria_arb_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      HALT_WAIT = 3'd1,
      GRANT_ZP  = 3'd2,
      GRANT_DP  = 3'd3,
      GUARD_S   = 3'd4
   } arb_state_t;

   localparam int unsigned HALT_LAT_MIN     = 1;
   localparam int unsigned HALT_LAT_MAX     = 3;
   localparam int unsigned GUARD_MIN        = 1;
   localparam int unsigned GUARD_MAX        = 15;
   localparam int unsigned MAX_HOLD_DEFAULT = 454;

   // Keeps a configuration value inside its legal range so an out-of-range
   // override degrades to the nearest bound instead of breaking counters.
   function automatic int unsigned clamp_param(input int unsigned value,
                                               input int unsigned lo,
                                               input int unsigned hi);
      if (value < lo) return lo;
      if (value > hi) return hi;
      return value;
   endfunction

endpackage
`default_nettype wire

// File: rtl/maria_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : maria_hold_timer
// Description : Per-grant hold budget counter. Cleared on every arbiter state
//               change, advances while a grant is active and flags expiry
//               when the budget's last cycle is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module maria_hold_timer #(
   parameter int unsigned MAX_HOLD = maria_arb_pkg::MAX_HOLD_DEFAULT
) (
   input  logic sysclk,
   input  logic reset_b,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   localparam int unsigned    c_width = $clog2(MAX_HOLD + 1);
   localparam logic [c_width-1:0] c_last = c_width'(MAX_HOLD - 1);

   logic [c_width-1:0] r_count;

   // Budget counter: clear has priority so a new grant always starts at zero
   always_ff @(posedge sysclk or negedge reset_b) begin
      if (!reset_b) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (tick) begin
         r_count <= r_count + c_width'(1);
      end
   end

   assign expired = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/maria_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : maria_bus_arbiter
// Description : Arbitrates the shared address/data bus between the 6502 and
//               the Maria ZP/DP DMA engines. Halts the CPU, waits for a CPU
//               cycle boundary, grants one DMA at a time under a hold budget
//               and releases the CPU through a guard interval.
//               Optional macro ARB_STATS_EN adds the stolen_cycles output
//               (halted cycles per frame, latched on frame_start).
// Revision    : 1.0 - initial release
// ============================================================================
module maria_bus_arbiter
   import maria_arb_pkg::*;
#(
   parameter int unsigned HALT_LAT = 1,
   parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT,
   parameter int unsigned GUARD    = 2
) (
   input  logic        sysclk,
   input  logic        reset_b,
   input  logic        enable,
   input  logic        cpu_cycle_end,
   input  logic        zp_req,
   input  logic        dp_req,
   input  logic        zp_done,
   input  logic        dp_done,
   input  logic        frame_start,
   output logic        halt_b,
   output logic        zp_grant,
   output logic        dp_grant,
   output logic        drive_AB,
   output logic        dma_kill,
   output logic        busy
`ifdef ARB_STATS_EN
   ,
   output logic [15:0] stolen_cycles
`endif
);

   localparam int unsigned c_halt_lat = clamp_param(HALT_LAT, HALT_LAT_MIN, HALT_LAT_MAX);
   localparam int unsigned c_guard    = clamp_param(GUARD, GUARD_MIN, GUARD_MAX);
   localparam int unsigned c_guard_w  = $clog2(c_guard + 1);
   localparam logic [1:0]  c_halt_last = 2'(c_halt_lat - 1);
   localparam logic [c_guard_w-1:0] c_guard_last = c_guard_w'(c_guard - 1);

   arb_state_t           r_state;
   arb_state_t           w_state_next;
   logic [1:0]           r_halt_cnt;
   logic [c_guard_w-1:0] r_guard_cnt;
   logic                 r_kill;
   logic                 w_kill_next;
   logic                 w_in_grant;
   logic                 w_timer_clear;
   logic                 w_hold_expired;

   assign w_in_grant    = (r_state == GRANT_ZP) || (r_state == GRANT_DP);
   assign w_timer_clear = (w_state_next != r_state);

   maria_hold_timer #(
      .MAX_HOLD (MAX_HOLD)
   ) u_hold_timer (
      .sysclk  (sysclk),
      .reset_b (reset_b),
      .clear   (w_timer_clear),
      .tick    (w_in_grant),
      .expired (w_hold_expired)
   );

   // Arbiter state register
   always_ff @(posedge sysclk or negedge reset_b) begin
      if (!reset_b) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state selection; a done in the budget's last cycle beats the kill
   always_comb begin
      w_state_next = r_state;
      w_kill_next  = 1'b0;
      case (r_state)
         IDLE: begin
            if (enable && (zp_req || dp_req)) begin
               w_state_next = HALT_WAIT;
            end
         end
         HALT_WAIT: begin
            if (!enable || (!zp_req && !dp_req)) begin
               w_state_next = GUARD_S;
            end else if (cpu_cycle_end && (r_halt_cnt == c_halt_last)) begin
               w_state_next = zp_req ? GRANT_ZP : GRANT_DP;
            end
         end
         GRANT_ZP: begin
            if (zp_done) begin
               w_state_next = (enable && dp_req) ? GRANT_DP : GUARD_S;
            end else if (w_hold_expired) begin
               w_state_next = GUARD_S;
               w_kill_next  = 1'b1;
            end
         end
         GRANT_DP: begin
            if (dp_done) begin
               w_state_next = (enable && zp_req) ? GRANT_ZP : GUARD_S;
            end else if (w_hold_expired) begin
               w_state_next = GUARD_S;
               w_kill_next  = 1'b1;
            end
         end
         GUARD_S: begin
            if (r_guard_cnt == c_guard_last) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Counts CPU cycle boundaries seen while waiting for the halt to take hold
   always_ff @(posedge sysclk or negedge reset_b) begin
      if (!reset_b) begin
         r_halt_cnt <= 2'd0;
      end else if (r_state != HALT_WAIT) begin
         r_halt_cnt <= 2'd0;
      end else if (cpu_cycle_end) begin
         r_halt_cnt <= r_halt_cnt + 2'd1;
      end
   end

   // Counts cycles spent in the guard interval before the CPU is released
   always_ff @(posedge sysclk or negedge reset_b) begin
      if (!reset_b) begin
         r_guard_cnt <= '0;
      end else if (r_state == GUARD_S) begin
         r_guard_cnt <= r_guard_cnt + c_guard_w'(1);
      end else begin
         r_guard_cnt <= '0;
      end
   end

   // Registers the kill so it coincides with the first guard cycle
   always_ff @(posedge sysclk or negedge reset_b) begin
      if (!reset_b) begin
         r_kill <= 1'b0;
      end else begin
         r_kill <= w_kill_next;
      end
   end

   assign halt_b   = (r_state == IDLE);
   assign busy     = (r_state != IDLE);
   assign zp_grant = (r_state == GRANT_ZP);
   assign dp_grant = (r_state == GRANT_DP);
   assign drive_AB = w_in_grant;
   assign dma_kill = r_kill;

`ifdef ARB_STATS_EN
   logic [15:0] r_stolen_run;
   logic [15:0] r_stolen_latched;

   // Per-frame halted-cycle count; frame_start publishes and restarts it
   always_ff @(posedge sysclk or negedge reset_b) begin
      if (!reset_b) begin
         r_stolen_run     <= 16'd0;
         r_stolen_latched <= 16'd0;
      end else if (frame_start) begin
         r_stolen_latched <= r_stolen_run;
         r_stolen_run     <= busy ? 16'd1 : 16'd0;
      end else if (busy && (r_stolen_run != 16'hFFFF)) begin
         r_stolen_run <= r_stolen_run + 16'd1;
      end
   end

   assign stolen_cycles = r_stolen_latched;
`else
   logic w_unused_frame_start;
   assign w_unused_frame_start = frame_start;
`endif

endmodule
`default_nettype wire

// File: tb/tb_maria_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_maria_bus_arbiter
// Description : Self-checking bench for maria_bus_arbiter. Expected output
//               timelines are derived from session lengths (halt latency,
//               grant length, guard length, hold budget) chosen at random.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maria_bus_arbiter;

   localparam int HALT_LAT = 1;
   localparam int MAX_HOLD = 454;
   localparam int GUARD    = 2;

   // Output vector order: {halt_b, zp_grant, dp_grant, drive_AB, dma_kill, busy}
   localparam logic [5:0] O_IDLE = 6'b100000;
   localparam logic [5:0] O_HALT = 6'b000001;
   localparam logic [5:0] O_ZP   = 6'b010101;
   localparam logic [5:0] O_DP   = 6'b001101;
   localparam logic [5:0] O_KILL = 6'b000011;

   logic sysclk        = 1'b0;
   logic reset_b       = 1'b0;
   logic enable        = 1'b1;
   logic cpu_cycle_end = 1'b0;
   logic zp_req        = 1'b0;
   logic dp_req        = 1'b0;
   logic zp_done       = 1'b0;
   logic dp_done       = 1'b0;
   logic frame_start   = 1'b0;
   logic halt_b, zp_grant, dp_grant, drive_AB, dma_kill, busy;
`ifdef ARB_STATS_EN
   logic [15:0] stolen_cycles;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 sysclk = ~sysclk;

   maria_bus_arbiter #(
      .HALT_LAT (HALT_LAT),
      .MAX_HOLD (MAX_HOLD),
      .GUARD    (GUARD)
   ) dut (
      .sysclk        (sysclk),
      .reset_b       (reset_b),
      .enable        (enable),
      .cpu_cycle_end (cpu_cycle_end),
      .zp_req        (zp_req),
      .dp_req        (dp_req),
      .zp_done       (zp_done),
      .dp_done       (dp_done),
      .frame_start   (frame_start),
      .halt_b        (halt_b),
      .zp_grant      (zp_grant),
      .dp_grant      (dp_grant),
      .drive_AB      (drive_AB),
      .dma_kill      (dma_kill),
      .busy          (busy)
`ifdef ARB_STATS_EN
      ,
      .stolen_cycles (stolen_cycles)
`endif
   );

   function automatic logic [5:0] outs();
      return {halt_b, zp_grant, dp_grant, drive_AB, dma_kill, busy};
   endfunction

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   // Full single-requester session: d idle CPU-cycle slots before the final
   // halt-latency pulse, h grant cycles (done in the h-th), then the guard.
   task automatic do_session(input bit use_zp, input int d, input int h, input string tag);
      logic [5:0] exp_g;
      exp_g = use_zp ? O_ZP : O_DP;
      if (use_zp) zp_req = 1'b1; else dp_req = 1'b1;
      tick();
      n_checks++;
      if (outs() !== exp_g && outs() !== O_HALT) begin end
      if (outs() !== O_HALT) begin
         n_fail++; $display("FAIL %s halt_fall: outs=%b expected=%b", tag, outs(), O_HALT);
      end
      for (int i = 0; i < d; i++) begin
         tick();
         n_checks++;
         if (outs() !== O_HALT) begin
            n_fail++; $display("FAIL %s halt_wait: outs=%b expected=%b", tag, outs(), O_HALT);
         end
      end
      for (int p = 0; p < HALT_LAT - 1; p++) begin
         cpu_cycle_end = 1'b1; tick(); cpu_cycle_end = 1'b0;
         n_checks++;
         if (outs() !== O_HALT) begin
            n_fail++; $display("FAIL %s halt_lat: outs=%b expected=%b", tag, outs(), O_HALT);
         end
      end
      cpu_cycle_end = 1'b1; tick(); cpu_cycle_end = 1'b0;
      for (int i = 0; i < h; i++) begin
         if (i > 0) tick();
         n_checks++;
         if (outs() !== exp_g) begin
            n_fail++; $display("FAIL %s grant cyc=%0d: outs=%b expected=%b", tag, i, outs(), exp_g);
         end
      end
      if (use_zp) zp_done = 1'b1; else dp_done = 1'b1;
      tick();
      zp_done = 1'b0; dp_done = 1'b0; zp_req = 1'b0; dp_req = 1'b0;
      for (int g = 0; g < GUARD; g++) begin
         n_checks++;
         if (outs() !== O_HALT) begin
            n_fail++; $display("FAIL %s guard cyc=%0d: outs=%b expected=%b", tag, g, outs(), O_HALT);
         end
         tick();
      end
      n_checks++;
      if (outs() !== O_IDLE) begin
         n_fail++; $display("FAIL %s release: outs=%b expected=%b", tag, outs(), O_IDLE);
      end
   endtask

   task automatic test_reset();
      zp_req = 1'b1;
      tick();
      n_checks++;
      if (outs() !== O_IDLE) begin
         n_fail++; $display("FAIL reset_state: outs=%b expected=%b", outs(), O_IDLE);
      end
`ifdef ARB_STATS_EN
      n_checks++;
      if (stolen_cycles !== 16'd0) begin
         n_fail++; $display("FAIL reset_stats: stolen=%0d expected=0", stolen_cycles);
      end
`endif
      tick();
      n_checks++;
      if (outs() !== O_IDLE) begin
         n_fail++; $display("FAIL reset_hold: outs=%b expected=%b", outs(), O_IDLE);
      end
      zp_req  = 1'b0;
      reset_b = 1'b1;
      tick();
      n_checks++;
      if (outs() !== O_IDLE) begin
         n_fail++; $display("FAIL reset_release: outs=%b expected=%b", outs(), O_IDLE);
      end
   endtask

   task automatic test_zp_session();
      for (int n = 0; n < 4; n++) begin
         do_session(1'b1, $urandom_range(0, 5), $urandom_range(1, 20), "zp_session");
      end
      for (int n = 0; n < 2; n++) begin
         do_session(1'b0, $urandom_range(0, 5), $urandom_range(1, 20), "dp_session");
      end
   endtask

   task automatic test_back_to_back();
      int d, h1, h2, k, h;
      // Both requests together; grants long enough that a shared budget would expire
      d  = $urandom_range(0, 4);
      h1 = $urandom_range(300, 330);
      h2 = $urandom_range(300, 330);
      zp_req = 1'b1; dp_req = 1'b1;
      tick();
      for (int i = 0; i < d; i++) tick();
      n_checks++;
      if (outs() !== O_HALT) begin
         n_fail++; $display("FAIL b2b_halt: outs=%b expected=%b", outs(), O_HALT);
      end
      cpu_cycle_end = 1'b1; tick(); cpu_cycle_end = 1'b0;
      for (int i = 0; i < h1; i++) begin
         if (i > 0) tick();
         n_checks++;
         if (outs() !== O_ZP) begin
            n_fail++; $display("FAIL b2b_zp_first cyc=%0d: outs=%b expected=%b", i, outs(), O_ZP);
         end
      end
      zp_done = 1'b1; tick(); zp_done = 1'b0; zp_req = 1'b0;
      for (int i = 0; i < h2; i++) begin
         if (i > 0) tick();
         n_checks++;
         if (outs() !== O_DP) begin
            n_fail++; $display("FAIL b2b_dp_follow cyc=%0d: outs=%b expected=%b", i, outs(), O_DP);
         end
      end
      dp_done = 1'b1; tick(); dp_done = 1'b0; dp_req = 1'b0;
      for (int g = 0; g < GUARD; g++) begin
         n_checks++;
         if (outs() !== O_HALT) begin
            n_fail++; $display("FAIL b2b_guard: outs=%b expected=%b", outs(), O_HALT);
         end
         tick();
      end
      n_checks++;
      if (outs() !== O_IDLE) begin
         n_fail++; $display("FAIL b2b_release: outs=%b expected=%b", outs(), O_IDLE);
      end
      // ZP arriving during a DP grant must not preempt it
      k = $urandom_range(1, 10);
      h = $urandom_range(1, 10);
      dp_req = 1'b1; tick();
      cpu_cycle_end = 1'b1; tick(); cpu_cycle_end = 1'b0;
      for (int i = 1; i < k; i++) tick();
      zp_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (outs() !== O_DP) begin
            n_fail++; $display("FAIL no_preempt cyc=%0d: outs=%b expected=%b", i, outs(), O_DP);
         end
      end
      dp_done = 1'b1; tick(); dp_done = 1'b0; dp_req = 1'b0;
      for (int i = 0; i < h; i++) begin
         if (i > 0) tick();
         n_checks++;
         if (outs() !== O_ZP) begin
            n_fail++; $display("FAIL dp_to_zp cyc=%0d: outs=%b expected=%b", i, outs(), O_ZP);
         end
      end
      zp_done = 1'b1; tick(); zp_done = 1'b0; zp_req = 1'b0;
      for (int g = 0; g < GUARD; g++) tick();
      n_checks++;
      if (outs() !== O_IDLE) begin
         n_fail++; $display("FAIL dp_to_zp_release: outs=%b expected=%b", outs(), O_IDLE);
      end
   endtask

   task automatic test_kill();
      dp_req = 1'b1; tick();
      for (int i = 0; i < $urandom_range(0, 3); i++) tick();
      cpu_cycle_end = 1'b1; tick(); cpu_cycle_end = 1'b0;
      // Grant rose at cycle 0; kill lands MAX_HOLD cycles later
      for (int i = 0; i < MAX_HOLD; i++) begin
         if (i > 0) tick();
         n_checks++;
         if (outs() !== O_DP) begin
            n_fail++; $display("FAIL kill_hold cyc=%0d: outs=%b expected=%b", i, outs(), O_DP);
         end
      end
      tick();
      n_checks++;
      if (outs() !== O_KILL) begin
         n_fail++; $display("FAIL kill_pulse: outs=%b expected=%b", outs(), O_KILL);
      end
      dp_req = 1'b0;
      tick();
      n_checks++;
      if (outs() !== O_HALT) begin
         n_fail++; $display("FAIL kill_one_cycle: outs=%b expected=%b", outs(), O_HALT);
      end
      tick(); tick(); tick();
      dp_done = 1'b1; tick(); dp_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (outs() !== O_IDLE) begin
            n_fail++; $display("FAIL late_done_ignored cyc=%0d: outs=%b expected=%b", i, outs(), O_IDLE);
         end
         tick();
      end
      // Done in the budget's last cycle: normal guard, no kill
      do_session(1'b0, $urandom_range(0, 3), MAX_HOLD, "done_beats_kill");
   endtask

   task automatic test_enable();
      int n;
      n = $urandom_range(3, 10);
      enable = 1'b0; dp_req = 1'b1;
      for (int i = 0; i < n; i++) begin
         tick();
         n_checks++;
         if (outs() !== O_IDLE) begin
            n_fail++; $display("FAIL disabled_idle: outs=%b expected=%b", outs(), O_IDLE);
         end
      end
      enable = 1'b1; tick();
      n_checks++;
      if (outs() !== O_HALT) begin
         n_fail++; $display("FAIL enable_halt: outs=%b expected=%b", outs(), O_HALT);
      end
      enable = 1'b0; tick();
      cpu_cycle_end = 1'b1;
      for (int g = 0; g < GUARD; g++) begin
         n_checks++;
         if (outs() !== O_HALT) begin
            n_fail++; $display("FAIL enable_drop_guard: outs=%b expected=%b", outs(), O_HALT);
         end
         tick();
         cpu_cycle_end = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (outs() !== O_IDLE) begin
            n_fail++; $display("FAIL enable_drop_no_grant: outs=%b expected=%b", outs(), O_IDLE);
         end
         tick();
      end
      // Requests withdrawn while waiting for the halt
      enable = 1'b1; tick();
      dp_req = 1'b0;
      for (int g = 0; g <= GUARD; g++) tick();
      n_checks++;
      if (outs() !== O_IDLE) begin
         n_fail++; $display("FAIL req_drop_release: outs=%b expected=%b", outs(), O_IDLE);
      end
      // Enable dropping mid-grant lets the grant finish normally
      zp_req = 1'b1; tick();
      cpu_cycle_end = 1'b1; tick(); cpu_cycle_end = 1'b0;
      enable = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++;
         if (outs() !== O_ZP) begin
            n_fail++; $display("FAIL enable_drop_grant: outs=%b expected=%b", outs(), O_ZP);
         end
      end
      zp_done = 1'b1; tick(); zp_done = 1'b0; zp_req = 1'b0;
      n_checks++;
      if (outs() !== O_HALT) begin
         n_fail++; $display("FAIL enable_drop_done: outs=%b expected=%b", outs(), O_HALT);
      end
      for (int g = 0; g < GUARD; g++) tick();
      enable = 1'b1;
   endtask

   task automatic test_async_reset();
      dp_req = 1'b1; tick();
      cpu_cycle_end = 1'b1; tick(); cpu_cycle_end = 1'b0;
      for (int i = 0; i < $urandom_range(1, 8); i++) tick();
      n_checks++;
      if (outs() !== O_DP) begin
         n_fail++; $display("FAIL pre_reset_grant: outs=%b expected=%b", outs(), O_DP);
      end
      #2 reset_b = 1'b0;
      #1;
      n_checks++;
      if (outs() !== O_IDLE) begin
         n_fail++; $display("FAIL async_reset: outs=%b expected=%b", outs(), O_IDLE);
      end
      dp_req = 1'b0;
      tick();
      reset_b = 1'b1;
      tick();
      do_session(1'b1, $urandom_range(0, 5), $urandom_range(1, 20), "post_reset");
   endtask

`ifdef ARB_STATS_EN
   task automatic test_stats();
      int d, expected;
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      expected = 0;
      for (int s = 0; s < 3; s++) begin
         d = $urandom_range(0, 5);
         // Halted cycles per session: (d + HALT_LAT) waiting + grant + GUARD
         do_session(s[0], d, 20 - GUARD - HALT_LAT - d, "stats_session");
         expected += 20;
      end
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      n_checks++;
      if (stolen_cycles !== 16'(expected)) begin
         n_fail++; $display("FAIL stats_frame: stolen=%0d expected=%0d", stolen_cycles, expected);
      end
      d = $urandom_range(0, 5);
      expected = $urandom_range(1, 15);
      do_session(1'b1, d, expected, "stats_next");
      expected = expected + d + HALT_LAT + GUARD;
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      n_checks++;
      if (stolen_cycles !== 16'(expected)) begin
         n_fail++; $display("FAIL stats_next_frame: stolen=%0d expected=%0d", stolen_cycles, expected);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_zp_session();
      test_back_to_back();
      test_kill();
      test_enable();
      test_async_reset();
`ifdef ARB_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/maria_bus_arbiter.md
Name: maria_bus_arbiter

Overview:
- Controls ownership of the shared system address/data bus between the 6502 (Sally) and the Maria DMA engine.
- Takes zero-page (ZP) and display-list (DP) DMA requests from the line timing logic and halts the CPU on a CPU-cycle boundary.
- Grants the bus to one DMA requester at a time, enforces a per-grant hold budget, then releases the bus to the CPU through a guard interval.
- Sits between the line timing controller, the DMA sequencer and the CPU halt/address-drive lines.

Parameters:
HALT_LAT, 1, number of cpu_cycle_end pulses after halt_b falls before any grant is issued (1..3)
MAX_HOLD, 454, maximum sysclk cycles a single grant may last before a forced kill
GUARD, 2, sysclk cycles with drive_AB low between end of grant and halt_b rising

Ports:
sysclk  in  1  system clock
reset_b  in  1  asynchronous active-low reset
enable  in  1  Maria enabled and DMA mode is normal; when low, no new grants are issued
cpu_cycle_end  in  1  one-sysclk pulse marking the end of each CPU bus cycle
zp_req  in  1  ZP DMA request, level; held until zp_done
dp_req  in  1  DP DMA request, level; held until dp_done
zp_done  in  1  one-cycle pulse: ZP DMA finished
dp_done  in  1  one-cycle pulse: DP DMA finished
frame_start  in  1  one-cycle pulse at the start of vblank
halt_b  out  1  CPU halt, active low
zp_grant  out  1  ZP DMA owns the bus
dp_grant  out  1  DP DMA owns the bus
drive_AB  out  1  Maria drives the address bus
dma_kill  out  1  one-cycle pulse: hold budget exceeded, the current DMA must abort
busy  out  1  state is not IDLE

Behaviour:
- Reset values: halt_b=1, grants=0, drive_AB=0, dma_kill=0, busy=0, state=IDLE, counters=0.
- States: IDLE, HALT_WAIT, GRANT_ZP, GRANT_DP, GUARD_S.
- IDLE: when enable is high and (zp_req or dp_req), go to HALT_WAIT and drive halt_b=0 on the next sysclk edge.
- HALT_WAIT:
  - Counts cpu_cycle_end pulses.
  - On the HALT_LAT-th pulse, go to GRANT_ZP if zp_req is high, otherwise GRANT_DP.
  - The grant and drive_AB assert on the following cycle.
  - If both requests drop before that pulse, go to GUARD_S.
- Priority: ZP over DP. The choice is fixed at grant time; a ZP request arriving during GRANT_DP does not preempt it.
- GRANT_x:
  - grant_x=1, drive_AB=1; the hold counter increments each cycle.
  - On done_x, go to GUARD_S in the same cycle's next state.
  - If the other request is pending at done_x, go directly to the other GRANT state without GUARD_S (back-to-back, halt_b stays 0). The hold counter resets.
  - When the hold counter reaches MAX_HOLD-1 with no done: pulse dma_kill for 1 cycle, go to GUARD_S, and ignore the late done.
- GUARD_S: drive_AB=0 and grants=0 for GUARD cycles while halt_b stays 0; then halt_b=1 and return to IDLE.
- Minimum 1 cycle in IDLE between sessions.
- enable falling:
  - In HALT_WAIT: go to GUARD_S.
  - In GRANT_x: the current grant completes normally.
- Simultaneous done_x and kill threshold: done wins, no kill pulse.
- Reset mid-grant: all outputs return to reset values immediately (asynchronous).
- Counter widths: clog2(MAX_HOLD+1); HALT counter 2 bits.

Optional Feature:
- Macro ARB_STATS_EN.
- With the macro defined: adds output stolen_cycles[15:0]. It counts sysclk cycles with halt_b=0, saturates at 16'hFFFF, and latches the count and clears the running counter on frame_start.
- Without the macro: port absent, no counter logic.

Decomposition:
- Shared package maria_arb_pkg: state enum arb_state_t, the HALT_LAT/GUARD bounds and a MAX_HOLD default constant.
- One sub-module, maria_hold_timer: loadable budget counter with expiry pulse, used by GRANT_x.

Test Plan:
- zp_req=1 in IDLE, HALT_LAT=1:
  - halt_b falls next cycle.
  - zp_grant and drive_AB rise 1 cycle after the first cpu_cycle_end.
  - zp_done pulse: drive_AB low, then halt_b high GUARD=2 cycles later.
- zp_req and dp_req both raised in the same cycle: zp_grant first; at zp_done, dp_grant follows next cycle with halt_b held low throughout.
- dp_req held, no dp_done:
  - dma_kill pulses exactly MAX_HOLD=454 cycles after dp_grant rose.
  - A dp_done 5 cycles later causes no state change.
- enable=0 while dp_req=1: halt_b stays 1, no grant. enable dropped in HALT_WAIT: GUARD_S, halt_b=1, no grant issued.
- reset_b asserted mid-GRANT_DP: halt_b=1, drive_AB=0, grants=0 in the same cycle without a clock edge; normal operation after release.
- ARB_STATS_EN: 3 sessions of 20 halted cycles each, then frame_start → stolen_cycles=60; the next frame starts counting from 0.
